uart_rx: RTL and testbench

Byte-oriented asynchronous serial receiver for the `rxd` pin. It sits between the board pin and the Peripheral block's UART receive data/status registers. It samples 8N1 frames at a fixed integer clocks-per-bit rate and holds the received byte with sticky status flags until software acknowledges it via a read-side `rx_ack` pulse.

---
 rtl/uart_rx.sv | 94 +++++++++
 tb/tb_uart_rx.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with byte holding register and sticky status flags
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_status,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       rx_busy
);
  localparam int H = CLKS_PER_BIT / 2;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;
  state_t state, state_n;
  logic s0, s1;
  logic [15:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shreg, shreg_n;
  logic good_n, ferr_n, good_p, ferr_p;
  logic tick_h, tick_c;
  assign tick_h = cnt == 16'(H - 1);
  assign tick_c = cnt == 16'(CLKS_PER_BIT - 1);
  always_comb begin
    state_n = state;
    cnt_n = cnt + 16'd1;
    idx_n = idx;
    shreg_n = shreg;
    good_n = 1'b0;
    ferr_n = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        state_n = s1 ? IDLE : START;
      end
      START: if (tick_h) begin
        cnt_n = '0;
        idx_n = '0;
        state_n = s1 ? IDLE : DATA;
      end
      DATA: if (tick_c) begin
        cnt_n = '0;
        shreg_n = {s1, shreg[7:1]};
        idx_n = idx + 3'd1;
        state_n = (idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (tick_c) begin
        cnt_n = '0;
        good_n = s1;
        ferr_n = !s1;
        state_n = s1 ? IDLE : WAITHI;
      end
      WAITHI: begin
        cnt_n = '0;
        state_n = s1 ? IDLE : WAITHI;
      end
      default: state_n = IDLE;
    endcase
  end
  // Frame outcome is registered one cycle, so the flag update lands on the edge after the stop sample
  always_ff @(posedge clk) begin
    if (reset) begin
      s0 <= 1'b1;
      s1 <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      good_p <= 1'b0;
      ferr_p <= 1'b0;
      rx_data <= '0;
      rx_status <= 1'b0;
      rx_overrun <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy <= 1'b0;
    end else begin
      s0 <= rxd;
      s1 <= s0;
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shreg <= shreg_n;
      good_p <= good_n;
      ferr_p <= ferr_n;
      rx_busy <= state != IDLE;
      rx_data <= good_p ? shreg : rx_data;
      rx_status <= good_p || (rx_status && !rx_ack);
      rx_overrun <= !rx_ack && (rx_overrun || (good_p && rx_status));
      rx_frame_err <= ferr_p || (!rx_ack && rx_frame_err);
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a timestamp-based receive model plus literal timing checks
module tb_uart_rx;
  localparam int C = 16;
  localparam int H = C / 2;
  logic clk = 0, reset = 1, rxd = 1, rx_ack = 0;
  logic [7:0] rx_data;
  logic rx_status, rx_overrun, rx_frame_err, rx_busy;
  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .reset(reset), .rxd(rxd), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_status(rx_status), .rx_overrun(rx_overrun),
    .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
  );
  always #5 clk = ~clk;
  int nchk = 0, nerr = 0, edge_n = 0;
  int st_rise = -1, bz_rise = -1, bz_fall = -1, fe_rise = -1;
  logic p_st = 0, p_bz = 0, p_fe = 0;
  bit rx_hist [0:8191];
  int rst_edge = 0, t0 = 0, mode = 0, pend = 0;
  logic [7:0] pend_byte, m_data;
  logic m_st, m_ov, m_fe, m_busy;
  logic ack_s, rst_s;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 40) $display("FAIL %s: got %0h expected %0h at edge %0d", n, act, exp, edge_n);
    end
  endtask
  // Synchronised line as seen by the receiver at edge x: two edges of latency, forced high after reset
  function automatic bit s1_at(input int x);
    return (x - 2 <= rst_edge) ? 1'b1 : rx_hist[x - 2];
  endfunction
  task automatic model_step();
    bit s;
    if (rst_s) begin
      m_data = 0; m_st = 0; m_ov = 0; m_fe = 0; m_busy = 0;
      mode = 0; pend = 0; rst_edge = edge_n;
    end else begin
      m_busy = mode != 0;
      if (pend == 1) begin
        m_data = pend_byte;
        if (ack_s) begin m_st = 1; m_ov = 0; m_fe = 0; end
        else if (m_st) m_ov = 1;
        else m_st = 1;
      end else if (pend == 2) begin
        m_fe = 1;
        if (ack_s) begin m_st = 0; m_ov = 0; end
      end else if (ack_s) begin
        m_st = 0; m_ov = 0; m_fe = 0;
      end
      pend = 0;
      s = s1_at(edge_n);
      if (mode == 0) begin
        if (!s) begin t0 = edge_n; mode = 1; end
      end else if (mode == 1) begin
        if (edge_n == t0 + H && s) mode = 0;
        else if (edge_n == t0 + H + 9 * C) begin
          for (int k = 0; k < 8; k++) pend_byte[k] = s1_at(t0 + H + (k + 1) * C);
          pend = s ? 1 : 2;
          mode = s ? 0 : 2;
        end
      end else if (s) mode = 0;
    end
  endtask
  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (edge_n < 8192) rx_hist[edge_n] = rxd;
      ack_s = rx_ack;
      rst_s = reset;
      model_step();
      #2;
      chk("data", rx_data, m_data);
      chk("status", rx_status, m_st);
      chk("overrun", rx_overrun, m_ov);
      chk("frame_err", rx_frame_err, m_fe);
      chk("busy", rx_busy, m_busy);
      if (rx_status && !p_st) st_rise = edge_n;
      if (rx_busy && !p_bz) bz_rise = edge_n;
      if (!rx_busy && p_bz) bz_fall = edge_n;
      if (rx_frame_err && !p_fe) fe_rise = edge_n;
      p_st = rx_status; p_bz = rx_busy; p_fe = rx_frame_err;
    end
  end
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic send_frame(input logic [7:0] b, input bit stop, output int e);
    e = edge_n;
    rxd = 0; step(C);
    for (int i = 0; i < 8; i++) begin rxd = b[i]; step(C); end
    rxd = stop; step(C);
  endtask
  task automatic pulse_ack();
    rx_ack = 1; step(1); rx_ack = 0;
  endtask
  initial begin
    int e, b;
    step(3);
    reset = 0;
    step(1);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_status", rx_status, 1'b0);
    chk("rst_busy", rx_busy, 1'b0);
    send_frame(8'h55, 1, e);
    chk("t1_busy_rise", bz_rise, e + 4);
    chk("t1_status_rise", st_rise, e + 3 + H + 9 * C + 1);
    chk("t1_busy_fall", bz_fall, e + 156);
    chk("t1_data", rx_data, 8'h55);
    chk("t1_flags", {rx_overrun, rx_frame_err}, 2'b00);
    send_frame(8'hA3, 1, e);
    send_frame(8'h3C, 1, e);
    step(4);
    chk("t2_data", rx_data, 8'h3C);
    chk("t2_status_ovr", {rx_status, rx_overrun}, 2'b11);
    pulse_ack();
    chk("t2_ack_flags", {rx_status, rx_overrun, rx_frame_err}, 3'b000);
    chk("t2_ack_data", rx_data, 8'h3C);
    e = edge_n;
    rxd = 0; step(5); rxd = 1; step(20);
    chk("t3_busy_rise", bz_rise, e + 4);
    chk("t3_busy_fall", bz_fall, e + 12);
    chk("t3_flags", {rx_status, rx_overrun, rx_frame_err}, 3'b000);
    send_frame(8'hFF, 0, e);
    step(40);
    chk("t4_fe_rise", fe_rise, e + 156);
    chk("t4_flags", {rx_frame_err, rx_status, rx_busy}, 3'b101);
    chk("t4_data", rx_data, 8'h3C);
    b = edge_n;
    rxd = 1; step(10);
    chk("t4_busy_fall", bz_fall, b + 4);
    pulse_ack();
    chk("t4_ack_fe", rx_frame_err, 1'b0);
    send_frame(8'h11, 1, e);
    chk("t5_first", {rx_status, rx_data}, 9'h111);
    fork
      send_frame(8'h22, 1, e);
      begin step(155); rx_ack = 1; step(1); rx_ack = 0; end
    join
    chk("t5_data", rx_data, 8'h22);
    chk("t5_flags", {rx_status, rx_overrun, rx_frame_err}, 3'b100);
    fork
      send_frame(8'h81, 1, e);
      begin
        step(85); reset = 1; step(1); reset = 0;
        chk("t6_rst_all", {rx_data, rx_status, rx_overrun, rx_frame_err, rx_busy}, 12'h000);
      end
    join
    step(40);
    chk("t6_no_byte", {rx_status, rx_data}, 9'h000);
    step(42);
    chk("t6_restart", {rx_status, rx_data}, 9'h1FC);
    step(20);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
